// File: rtl/tick_period_meter_pkg.sv
// Shared types and default sizing for the tick period meter.
package tick_period_meter_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_LOCK_N = 4;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

endpackage

// File: rtl/tick_period_meter_edge_det.sv
// Rising-edge detector for an mclk-synchronous pulse stream.
module tick_edge_det (
  input  logic mclk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures rise-to-rise spacing of tick_in in mclk cycles and declares lock
// once LOCK_N consecutive periods equal exp_period.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] exp_period,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             miss,
  output logic             ovf
);

  localparam int            MW        = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_N);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [MW-1:0]    matchCnt_q, matchCnt_d;
  logic             periodVld_q, periodVld_d;
  logic             miss_q, miss_d;
  logic             ovf_q, ovf_d;
  logic             rise;
  logic             isMatch;

  tick_edge_det u_edge (
    .mclk  (mclk),
    .rst_n (rst_n),
    .in    (tick_in),
    .rise  (rise)
  );

  // A zero expectation can never be met, since a captured period is at least 1.
  assign isMatch = (exp_period != '0) && (cnt_q == exp_period);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    matchCnt_d  = matchCnt_q;
    periodVld_d = 1'b0;
    miss_d      = 1'b0;
    ovf_d       = ovf_q;

    if (clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      period_d   = '0;
      matchCnt_d = '0;
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_W'(1);
          end
        end
        MEAS: begin
          if (rise) begin
            period_d    = cnt_q;
            cnt_d       = CNT_W'(1);
            periodVld_d = 1'b1;
            if (isMatch) begin
              if (matchCnt_q != MATCH_MAX) begin
                matchCnt_d = matchCnt_q + MW'(1);
              end
            end else begin
              matchCnt_d = '0;
              miss_d     = 1'b1;
            end
          end else if (cnt_q == '1) begin
            // Saturated without an edge: the period is unknowable, so re-arm.
            state_d    = IDLE;
            cnt_d      = '0;
            matchCnt_d = '0;
            ovf_d      = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      matchCnt_q  <= '0;
      periodVld_q <= 1'b0;
      miss_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      matchCnt_q  <= matchCnt_d;
      periodVld_q <= periodVld_d;
      miss_q      <= miss_d;
      ovf_q       <= ovf_d;
    end
  end

  assign period     = period_q;
  assign period_vld = periodVld_q;
  assign miss       = miss_q;
  assign ovf        = ovf_q;
  assign locked     = (matchCnt_q == MATCH_MAX);

endmodule
